// File: rtl/lights_out_pkg.sv
// Shared types, constants and press-mask helper for the Lights Out core.
// Build option: define TORUS_EN for wrap-around neighbours.
package lights_out_pkg;

    typedef enum logic [1:0] {
        SCRAMBLE = 2'd0,
        PLAY     = 2'd1,
        SOLVED   = 2'd2
    } state_t;

    // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'h0001;
    localparam int          MAX_CELLS    = 64;

    function automatic logic [MAX_CELLS-1:0] press_mask(input logic [7:0] idx,
                                                        input int rows,
                                                        input int cols);
        int r;
        int c;
        logic [MAX_CELLS-1:0] m;
        r = int'(idx) / cols;
        c = int'(idx) % cols;
        m = 64'd1 << (r * cols + c);
`ifdef TORUS_EN
        m = m | (64'd1 << (((r + rows - 1) % rows) * cols + c));
        m = m | (64'd1 << (((r + 1) % rows) * cols + c));
        m = m | (64'd1 << (r * cols + (c + cols - 1) % cols));
        m = m | (64'd1 << (r * cols + (c + 1) % cols));
`else
        if (r > 0)        m = m | (64'd1 << ((r - 1) * cols + c));
        if (r < rows - 1) m = m | (64'd1 << ((r + 1) * cols + c));
        if (c > 0)        m = m | (64'd1 << (r * cols + c - 1));
        if (c < cols - 1) m = m | (64'd1 << (r * cols + c + 1));
`endif
        return m;
    endfunction

endpackage

// File: rtl/lights_out_lfsr.sv
// 16-bit Fibonacci LFSR with seed load, zero-seed fixup and advance enable.
module lights_out_lfsr
    import lights_out_pkg::*;
(
    input  logic        clk,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        adv,
    output logic [7:0]  sample
);

    logic [15:0] lfsr_r;
    logic        fb_s;

    assign fb_s   = ^(lfsr_r & LFSR_TAPS);
    assign sample = lfsr_r[7:0];

    // Load (never with an all-zero lock-up value) or shift one step.
    always_ff @(posedge clk) begin
        if (load) begin
            lfsr_r <= (seed == 16'h0000) ? DEFAULT_SEED : seed;
        end else if (adv) begin
            lfsr_r <= {lfsr_r[14:0], fb_s};
        end
    end

endmodule

// File: rtl/lights_out_grid.sv
// Lights Out game core: LFSR scramble, edge-detected presses, move count, win.
// Build option: define TORUS_EN for wrap-around neighbours.
module lights_out_grid
    import lights_out_pkg::*;
#(
    parameter int ROWS           = 3,
    parameter int COLS           = 3,
    parameter int SCRAMBLE_MOVES = 8,
    parameter int MOVE_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [ROWS*COLS-1:0]   btn,
    input  logic [15:0]            seed,
    output logic [ROWS*COLS-1:0]   field,
    output logic                   busy,
    output logic                   solved,
    output logic [MOVE_W-1:0]      moves
);

    localparam int              NCELL   = ROWS * COLS;
    localparam int              CNT_W   = $clog2(SCRAMBLE_MOVES + 1);
    localparam logic [CNT_W-1:0] SCR_CNT = CNT_W'(SCRAMBLE_MOVES);
    localparam logic [7:0]      NCELL_B = 8'(NCELL);

    state_t               state_r, state_nxt_s;
    logic [NCELL-1:0]     field_r, field_nxt_s;
    logic [NCELL-1:0]     btn_q_r;
    logic [NCELL-1:0]     edge_s;
    logic [MOVE_W-1:0]    moves_r, moves_nxt_s;
    logic [CNT_W-1:0]     count_r, count_nxt_s;
    logic                 busy_r;
    logic                 solved_r;
    logic [7:0]           lfsr_s;
    logic [7:0]           scr_idx_s;
    logic [7:0]           win_s;
    logic [MAX_CELLS-1:0] scr_mask_s;
    logic [MAX_CELLS-1:0] win_mask_s;

    lights_out_lfsr u_lfsr (
        .clk    (clk),
        .load   (~rst_n),
        .seed   (seed),
        .adv    (ena && (state_r == SCRAMBLE)),
        .sample (lfsr_s)
    );

    assign scr_idx_s  = lfsr_s % NCELL_B;
    assign edge_s     = btn & ~btn_q_r;
    assign scr_mask_s = press_mask(scr_idx_s, ROWS, COLS);
    assign win_mask_s = press_mask(win_s, ROWS, COLS);

    // Lowest-index rising edge wins; scan downward so the last hit is the lowest.
    always_comb begin
        win_s = 8'd0;
        for (int i = NCELL - 1; i >= 0; i--) begin
            if (((edge_s >> i) & NCELL'(1)) != '0) begin
                win_s = 8'(i);
            end else begin
                win_s = win_s;
            end
        end
    end

    // Next-state and datapath update for scramble, play and solved.
    always_comb begin
        state_nxt_s = state_r;
        field_nxt_s = field_r;
        moves_nxt_s = moves_r;
        count_nxt_s = count_r;
        case (state_r)
            SCRAMBLE: begin
                field_nxt_s = field_r ^ scr_mask_s[NCELL-1:0];
                if (count_r != SCR_CNT) begin
                    count_nxt_s = count_r + CNT_W'(1);
                end else begin
                    count_nxt_s = count_r;
                end
                // Keep pressing past the budget until the board is not already solved.
                if ((count_nxt_s == SCR_CNT) && (field_nxt_s != '0)) begin
                    state_nxt_s = PLAY;
                end else begin
                    state_nxt_s = SCRAMBLE;
                end
            end
            PLAY: begin
                if (edge_s != '0) begin
                    field_nxt_s = field_r ^ win_mask_s[NCELL-1:0];
                    if (moves_r != {MOVE_W{1'b1}}) begin
                        moves_nxt_s = moves_r + MOVE_W'(1);
                    end else begin
                        moves_nxt_s = moves_r;
                    end
                    if (field_nxt_s == '0) begin
                        state_nxt_s = SOLVED;
                    end else begin
                        state_nxt_s = PLAY;
                    end
                end else begin
                    state_nxt_s = PLAY;
                end
            end
            SOLVED: begin
                state_nxt_s = SOLVED;
            end
            default: begin
                state_nxt_s = SCRAMBLE;
            end
        endcase
    end

    // State and output registers; ena low freezes everything except reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= SCRAMBLE;
            field_r  <= '0;
            moves_r  <= '0;
            count_r  <= '0;
            busy_r   <= 1'b1;
            solved_r <= 1'b0;
            btn_q_r  <= btn;
        end else if (ena) begin
            state_r  <= state_nxt_s;
            field_r  <= field_nxt_s;
            moves_r  <= moves_nxt_s;
            count_r  <= count_nxt_s;
            busy_r   <= (state_nxt_s == SCRAMBLE);
            solved_r <= (state_nxt_s == SOLVED);
            btn_q_r  <= btn;
        end
    end

    assign field  = field_r;
    assign busy   = busy_r;
    assign solved = solved_r;
    assign moves  = moves_r;

endmodule

// File: tb/tb_lights_out_grid.sv
// Directed self-checking bench for lights_out_grid (3x3, planar build).
module tb_lights_out_grid;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic [8:0]  btn = 9'h000;
    logic [15:0] seed = 16'h0004;

    logic [8:0]  field_a, field_b, field_c;
    logic        busy_a, busy_b, busy_c;
    logic        solved_a, solved_b, solved_c;
    logic [7:0]  moves_a, moves_c;
    logic [1:0]  moves_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lights_out_grid #(.ROWS(3), .COLS(3), .SCRAMBLE_MOVES(1), .MOVE_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .btn(btn), .seed(seed),
        .field(field_a), .busy(busy_a), .solved(solved_a), .moves(moves_a));

    lights_out_grid #(.ROWS(3), .COLS(3), .SCRAMBLE_MOVES(1), .MOVE_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .btn(btn), .seed(seed),
        .field(field_b), .busy(busy_b), .solved(solved_b), .moves(moves_b));

    lights_out_grid #(.ROWS(3), .COLS(3), .SCRAMBLE_MOVES(2), .MOVE_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .ena(ena), .btn(btn), .seed(seed),
        .field(field_c), .busy(busy_c), .solved(solved_c), .moves(moves_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic press(input int k);
        btn = 9'(1 << k);
        tick();
        btn = 9'h000;
        tick();
    endtask

    initial begin
        #1;
        // Reset state and single-press scramble
        seed = 16'h0004;
        do_reset();
        check_val("rst_field", 32'(field_a), 32'h0);
        check_val("rst_busy", 32'(busy_a), 32'h1);
        check_val("rst_solved", 32'(solved_a), 32'h0);
        check_val("rst_moves", 32'(moves_a), 32'h0);
        tick();
        check_val("scr_field", 32'(field_a), 32'h0BA);
        check_val("scr_busy", 32'(busy_a), 32'h0);
        check_val("scr_moves", 32'(moves_a), 32'h0);
        check_val("scr2_busy_mid", 32'(busy_c), 32'h1);
        check_val("scr2_field_mid", 32'(field_c), 32'h0BA);
        tick();
        check_val("scr2_field", 32'(field_c), 32'h11A);
        check_val("scr2_busy", 32'(busy_c), 32'h0);

        // Winning press then ignored presses
        btn = 9'h010;
        tick();
        check_val("win_field", 32'(field_a), 32'h0);
        check_val("win_solved", 32'(solved_a), 32'h1);
        check_val("win_moves", 32'(moves_a), 32'h1);
        btn = 9'h000;
        tick();
        press(0);
        press(5);
        check_val("solved_hold_field", 32'(field_a), 32'h0);
        check_val("solved_hold_moves", 32'(moves_a), 32'h1);
        check_val("solved_hold_flag", 32'(solved_a), 32'h1);

        // Same cell twice restores the board
        do_reset();
        tick();
        btn = 9'h001;
        tick();
        check_val("p0_field", 32'(field_a), 32'h0B1);
        check_val("p0_moves", 32'(moves_a), 32'h1);
        btn = 9'h000;
        tick();
        btn = 9'h001;
        tick();
        check_val("p0b_field", 32'(field_a), 32'h0BA);
        check_val("p0b_moves", 32'(moves_a), 32'h2);
        btn = 9'h000;

        // Simultaneous edges: lowest index wins, holding adds nothing
        do_reset();
        tick();
        btn = 9'h044;
        tick();
        check_val("prio_field", 32'(field_a), 32'h09C);
        check_val("prio_moves", 32'(moves_a), 32'h1);
        repeat (10) tick();
        check_val("hold_field", 32'(field_a), 32'h09C);
        check_val("hold_moves", 32'(moves_a), 32'h1);
        btn = 9'h000;

        // Button held through reset, pulse inside an ena-low window
        btn = 9'h008;
        do_reset();
        tick();
        tick();
        check_val("held_field", 32'(field_a), 32'h0BA);
        check_val("held_moves", 32'(moves_a), 32'h0);
        ena = 1'b0;
        tick();
        btn = 9'h108;
        tick();
        tick();
        btn = 9'h008;
        tick();
        tick();
        ena = 1'b1;
        tick();
        check_val("ena_field", 32'(field_a), 32'h0BA);
        check_val("ena_moves", 32'(moves_a), 32'h0);
        btn = 9'h000;
        tick();

        // Five presses: wide counter counts, narrow one saturates
        do_reset();
        tick();
        press(0);
        press(1);
        press(2);
        press(5);
        press(8);
        check_val("sat_field", 32'(field_a), 32'h014);
        check_val("sat_moves_w8", 32'(moves_a), 32'h5);
        check_val("sat_moves_w2", 32'(moves_b), 32'h3);
        check_val("sat_solved", 32'(solved_b), 32'h0);

        // Zero seed behaves like seed 1
        seed = 16'h0000;
        do_reset();
        tick();
        check_val("seed0_field", 32'(field_a), 32'h017);
        tick();
        check_val("seed0_field2", 32'(field_c), 32'h031);
        seed = 16'h0001;
        do_reset();
        tick();
        check_val("seed1_field", 32'(field_a), 32'h017);
        tick();
        check_val("seed1_field2", 32'(field_c), 32'h031);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
